yrv_aux_uart_tx: RTL and testbench
==================================

Name: yrv_aux_uart_tx

Overview:
Transmit half of the MCU auxiliary UART; it drives the serial line that the aux_uart_rx pin listens to.
- Accepts bytes over a valid/ready interface into a small FIFO.
- Serializes them LSB-first with start bit, optional parity, and 1 or 2 stop bits.
- Bit period comes from a programmable divisor.
- Sits beside the aux receiver inside yrv_mcu; software writes through a port/MMIO register.

Parameters:
FIFO_DEPTH, 8, transmit FIFO entries; power of 2, minimum 2.
DIV_W, 16, width of the baud divisor.

Ports:
clk  input  1  cpu clock.
resetb  input  1  master reset, synchronous, active-low.
baud_div  input  DIV_W  bit period is baud_div+1 clocks.
par_en  input  1  1 = append parity bit.
par_odd  input  1  1 = odd parity, 0 = even parity.
stop2  input  1  1 = two stop bits, 0 = one stop bit.
tx_data  input  8  byte to send.
tx_valid  input  1  tx_data is valid.
tx_ready  output  1  FIFO can accept a byte.
aux_uart_tx  output  1  serial line, idles high.
tx_busy  output  1  a frame is in progress.
tx_empty  output  1  FIFO empty and not busy; all data has left the line.
fifo_count  output  $clog2(FIFO_DEPTH)+1  bytes held in the FIFO.

Behaviour:
- Clocking and reset: one clock, clk. Reset is synchronous and active-low on resetb.
- Reset values, applied at the first clk edge with resetb=0:
  - aux_uart_tx=1, tx_busy=0, tx_empty=1, fifo_count=0, tx_ready=1.
  - FSM goes to IDLE and the FIFO pointers clear.
  - A reset mid-frame truncates the frame: the line returns high at that edge and the FIFO contents are discarded.
- FIFO:
  - Push when tx_valid & tx_ready at a clk edge.
  - tx_ready = (fifo_count != FIFO_DEPTH), combinational from registered count.
  - Simultaneous push and pop leaves the count unchanged.
  - A push while full cannot occur (ready=0), and tx_data is ignored.
  - Pointers wrap modulo FIFO_DEPTH.
- FSM states: IDLE, START, DATA, PARITY, STOP.
  - A bit counter (0..7) selects data bits; a stop counter (0..1) tracks stop bits.
  - A divisor counter loads baud_div at entry to each bit and decrements; the bit ends when it reaches 0. Each bit therefore lasts exactly baud_div+1 clocks, and baud_div=0 gives 1 clock per bit.
- IDLE:
  - If the FIFO is non-empty, pop the byte into the shift register.
  - Latch par_en, par_odd, stop2 and baud_div for the whole frame; changes mid-frame affect the next frame only.
  - Drive aux_uart_tx=0 and go to START.
- Latency: with the FSM in IDLE and the FIFO empty, a byte accepted at edge k makes aux_uart_tx fall at edge k+1.
- START: line 0 for one bit time, then DATA.
- DATA: line = shift[0], shifting right each bit, for 8 bits LSB first. Then PARITY if par_en, else STOP.
- PARITY: line = ^data XOR par_odd for one bit time.
- STOP: line 1 for 1 bit time, or 2 if stop2. At the end of the final stop bit:
  - If the FIFO is non-empty, pop and go directly to START at the same edge. Back-to-back frames have no idle gap.
  - Otherwise go to IDLE.
- Frame length: (10 + par_en + stop2) × (baud_div+1) clocks.
- tx_busy is 1 in all states except IDLE.
- aux_uart_tx is registered, with no combinational path from the inputs.

Test Plan:
- Single frame, 8N1, 0x55, baud_div=3: line low at edge k+1, then bit sequence 0,1,0,1,0,1,0,1,0,1, each bit 4 clocks, then high. tx_busy is high for 40 clocks, then tx_empty=1.
- Parity on 0x07, baud_div=1: even parity gives parity bit 1, odd gives 0. stop2=1 gives 2 stop bits. Frame length is 12 bits × 2 = 24 clocks.
- Burst of 10 bytes 0x00..0x09 with tx_valid held high, FIFO_DEPTH=8, baud_div=0:
  - tx_ready drops once fifo_count reaches 8.
  - All 10 bytes are sent in order, 10 clocks per frame, with no idle cycles between frames.
- Configuration change mid-frame: switch par_en 0->1 during DATA of frame 1. Frame 1 has no parity bit; frame 2 has one.
- Reset at clock 15 of a 0xA5 frame with 3 bytes queued: aux_uart_tx=1, fifo_count=0, tx_busy=0 at that edge. The line stays high afterwards.
- baud_div=0xFFFF on one 0xFF byte: each bit lasts 65536 clocks, with no counter overflow or early bit end.

Source files
------------

// File: rtl/yrv_aux_uart_tx.sv
// yrv_aux_uart_tx: transmit half of the MCU auxiliary UART.
// Byte FIFO feeding a start/data/parity/stop serializer with a programmable bit period.
module yrv_aux_uart_tx #(
    parameter int FIFO_DEPTH = 8,
    parameter int DIV_W      = 16
) (
    input  logic                          clk,
    input  logic                          resetb,
    input  logic [DIV_W-1:0]              baud_div,
    input  logic                          par_en,
    input  logic                          par_odd,
    input  logic                          stop2,
    input  logic [7:0]                    tx_data,
    input  logic                          tx_valid,
    output logic                          tx_ready,
    output logic                          aux_uart_tx,
    output logic                          tx_busy,
    output logic                          tx_empty,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic [AW:0] FULL = (AW+1)'(FIFO_DEPTH);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } state_t;

    state_t state, state_n;

    logic [7:0]       mem [FIFO_DEPTH];
    logic [AW-1:0]    wr_ptr, rd_ptr;
    logic [AW:0]      count;
    logic             push, pop, load;

    logic [DIV_W-1:0] div_cnt, div_n;
    logic [DIV_W-1:0] cfg_div, cfg_div_n;
    logic [2:0]       bit_cnt, bit_n;
    logic             stop_cnt, stop_n;
    logic [7:0]       shift, shift_n;
    logic             cfg_pe, cfg_pe_n;
    logic             cfg_s2, cfg_s2_n;
    logic             par_bit, par_bit_n;
    logic             line, line_n;
    logic             bit_end;

    assign tx_ready    = (count != FULL);
    assign push        = tx_valid & tx_ready;
    assign fifo_count  = count;
    assign aux_uart_tx = line;
    assign tx_busy     = (state != IDLE);
    assign tx_empty    = (count == '0) && (state == IDLE);
    assign bit_end     = (div_cnt == '0);

    // FIFO storage write port
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= tx_data;
        end
    end

    // FIFO pointers and occupancy
    always_ff @(posedge clk) begin
        if (!resetb) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // serializer state register
    always_ff @(posedge clk) begin
        if (!resetb) begin
            state    <= IDLE;
            div_cnt  <= '0;
            cfg_div  <= '0;
            bit_cnt  <= '0;
            stop_cnt <= 1'b0;
            shift    <= '0;
            cfg_pe   <= 1'b0;
            cfg_s2   <= 1'b0;
            par_bit  <= 1'b0;
            line     <= 1'b1;
        end else begin
            state    <= state_n;
            div_cnt  <= div_n;
            cfg_div  <= cfg_div_n;
            bit_cnt  <= bit_n;
            stop_cnt <= stop_n;
            shift    <= shift_n;
            cfg_pe   <= cfg_pe_n;
            cfg_s2   <= cfg_s2_n;
            par_bit  <= par_bit_n;
            line     <= line_n;
        end
    end

    // next-state: bit timing, framing and frame load (from IDLE or end of STOP)
    always_comb begin
        state_n   = state;
        div_n     = div_cnt;
        cfg_div_n = cfg_div;
        bit_n     = bit_cnt;
        stop_n    = stop_cnt;
        shift_n   = shift;
        cfg_pe_n  = cfg_pe;
        cfg_s2_n  = cfg_s2;
        par_bit_n = par_bit;
        line_n    = line;
        pop       = 1'b0;
        load      = 1'b0;
        case (state)
            IDLE: begin
                load = (count != '0);
            end
            START: begin
                if (bit_end) begin
                    state_n = DATA;
                    div_n   = cfg_div;
                    bit_n   = '0;
                    line_n  = shift[0];
                end else begin
                    div_n = div_cnt - 1'b1;
                end
            end
            DATA: begin
                if (bit_end) begin
                    div_n = cfg_div;
                    if (bit_cnt == 3'd7) begin
                        if (cfg_pe) begin
                            state_n = PARITY;
                            line_n  = par_bit;
                        end else begin
                            state_n = STOP;
                            stop_n  = 1'b0;
                            line_n  = 1'b1;
                        end
                    end else begin
                        bit_n   = bit_cnt + 1'b1;
                        shift_n = {1'b0, shift[7:1]};
                        line_n  = shift[1];
                    end
                end else begin
                    div_n = div_cnt - 1'b1;
                end
            end
            PARITY: begin
                if (bit_end) begin
                    state_n = STOP;
                    div_n   = cfg_div;
                    stop_n  = 1'b0;
                    line_n  = 1'b1;
                end else begin
                    div_n = div_cnt - 1'b1;
                end
            end
            STOP: begin
                if (bit_end) begin
                    if (cfg_s2 && !stop_cnt) begin
                        stop_n = 1'b1;
                        div_n  = cfg_div;
                    end else if (count != '0) begin
                        load = 1'b1;
                    end else begin
                        state_n = IDLE;
                    end
                end else begin
                    div_n = div_cnt - 1'b1;
                end
            end
            default: begin
                state_n = IDLE;
                line_n  = 1'b1;
            end
        endcase
        if (load) begin
            pop       = 1'b1;
            shift_n   = mem[rd_ptr];
            par_bit_n = (^mem[rd_ptr]) ^ par_odd;
            cfg_pe_n  = par_en;
            cfg_s2_n  = stop2;
            cfg_div_n = baud_div;
            div_n     = baud_div;
            line_n    = 1'b0;
            state_n   = START;
        end
    end

endmodule

// File: tb/tb_yrv_aux_uart_tx.sv
// tb_yrv_aux_uart_tx: directed bench for the aux UART transmitter.
// Stimulus queues expected frames; a line monitor decodes and compares them.
module tb_yrv_aux_uart_tx;

    logic        clk = 1'b0;
    logic        resetb;
    logic [15:0] baud_div;
    logic        par_en, par_odd, stop2;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready;
    logic        aux_uart_tx;
    logic        tx_busy;
    logic        tx_empty;
    logic [3:0]  fifo_count;

    typedef struct {
        logic [7:0] d;
        logic       pe;
        logic       pb;
        logic       s2;
        int         div;
        logic       b2b;
    } exp_t;

    exp_t exp_q[$];
    int   total = 0;
    int   bad   = 0;
    logic mon_en = 1'b1;

    yrv_aux_uart_tx #(.FIFO_DEPTH(8), .DIV_W(16)) dut (
        .clk        (clk),
        .resetb     (resetb),
        .baud_div   (baud_div),
        .par_en     (par_en),
        .par_odd    (par_odd),
        .stop2      (stop2),
        .tx_data    (tx_data),
        .tx_valid   (tx_valid),
        .tx_ready   (tx_ready),
        .aux_uart_tx(aux_uart_tx),
        .tx_busy    (tx_busy),
        .tx_empty   (tx_empty),
        .fifo_count (fifo_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, req);
        end
    endtask

    task automatic send(input logic [7:0] d, input logic pe, input logic pb,
                        input logic s2, input int div, input logic b2b,
                        input logic with_exp);
        @(negedge clk);
        tx_data  = d;
        tx_valid = 1'b1;
        if (with_exp) exp_q.push_back('{d, pe, pb, s2, div, b2b});
        @(posedge clk);
        #1 tx_valid = 1'b0;
    endtask

    task automatic lat_len(input int len);
        int n;
        @(negedge clk);
        chk("lat_edge_k_high", aux_uart_tx, 1'b1);
        @(negedge clk);
        chk("lat_edge_k1_low", aux_uart_tx, 1'b0);
        n = 0;
        while (tx_busy && n < 100000) begin
            n++;
            @(negedge clk);
        end
        chk("busy_len", n, len);
        chk("empty_after", tx_empty, 1'b1);
    endtask

    task automatic wait_done();
        int n;
        n = 0;
        while ((exp_q.size() != 0 || !tx_empty) && n < 5000) begin
            @(negedge clk);
            n++;
        end
        chk("drain_timeout", n < 5000, 1'b1);
        repeat (2) @(negedge clk);
    endtask

    // line monitor: decodes each frame and compares it with the queue head
    initial begin
        exp_t e;
        int   idle;
        int   nb;
        logic bv, act;
        idle = 0;
        forever begin
            @(negedge clk);
            if (mon_en && resetb && aux_uart_tx == 1'b0) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_start", exp_q.size(), 1);
                end else begin
                    e = exp_q.pop_front();
                    if (e.b2b) chk("b2b_gap", idle, 0);
                    nb = 10 + int'(e.pe) + int'(e.s2);
                    for (int i = 0; i < nb; i++) begin
                        if (i == 0)                bv = 1'b0;
                        else if (i <= 8)           bv = e.d[i-1];
                        else if (e.pe && i == 9)   bv = e.pb;
                        else                       bv = 1'b1;
                        act = bv;
                        for (int c = 0; c <= e.div; c++) begin
                            if (!(i == 0 && c == 0)) @(negedge clk);
                            if (aux_uart_tx !== bv) act = aux_uart_tx;
                        end
                        chk($sformatf("frame_%02h_bit%0d", e.d, i), act, bv);
                    end
                    idle = 0;
                end
            end else begin
                idle++;
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int   n;
        int   cyc;
        int   low;
        logic saw_full;
        resetb   = 1'b0;
        baud_div = 16'd3;
        par_en   = 1'b0;
        par_odd  = 1'b0;
        stop2    = 1'b0;
        tx_data  = 8'h00;
        tx_valid = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_line", aux_uart_tx, 1'b1);
        chk("rst_busy", tx_busy, 1'b0);
        chk("rst_empty", tx_empty, 1'b1);
        chk("rst_count", fifo_count, 4'd0);
        chk("rst_ready", tx_ready, 1'b1);
        resetb = 1'b1;
        repeat (2) @(negedge clk);

        // 8N1 0x55, 4 clocks per bit
        send(8'h55, 1'b0, 1'b0, 1'b0, 3, 1'b0, 1'b1);
        lat_len(40);
        wait_done();

        // parity on 0x07, two stop bits, 2 clocks per bit
        baud_div = 16'd1;
        par_en   = 1'b1;
        stop2    = 1'b1;
        par_odd  = 1'b0;
        send(8'h07, 1'b1, 1'b1, 1'b1, 1, 1'b0, 1'b1);
        lat_len(24);
        wait_done();
        par_odd = 1'b1;
        send(8'h07, 1'b1, 1'b0, 1'b1, 1, 1'b0, 1'b1);
        lat_len(24);
        wait_done();

        // burst of ten bytes at 1 clock per bit
        baud_div = 16'd0;
        par_en   = 1'b0;
        par_odd  = 1'b0;
        stop2    = 1'b0;
        n        = 0;
        cyc      = 0;
        saw_full = 1'b0;
        @(negedge clk);
        while (n < 10 && cyc < 500) begin
            tx_valid = 1'b1;
            tx_data  = n[7:0];
            if (fifo_count == 4'd8) begin
                chk("ready_when_full", tx_ready, 1'b0);
                saw_full = 1'b1;
            end
            chk("count_max", fifo_count <= 4'd8, 1'b1);
            if (tx_ready) begin
                exp_q.push_back('{n[7:0], 1'b0, 1'b0, 1'b0, 0, n != 0});
                n++;
            end
            @(negedge clk);
            cyc++;
        end
        tx_valid = 1'b0;
        chk("burst_accepted", n, 10);
        chk("burst_saw_full", saw_full, 1'b1);
        wait_done();

        // par_en switched on during DATA of the first frame
        baud_div = 16'd1;
        send(8'h3C, 1'b0, 1'b0, 1'b0, 1, 1'b0, 1'b1);
        send(8'hC1, 1'b1, 1'b1, 1'b0, 1, 1'b1, 1'b1);
        repeat (6) @(negedge clk);
        par_en = 1'b1;
        wait_done();
        par_en = 1'b0;

        // reset mid-frame with bytes queued
        mon_en = 1'b0;
        send(8'hA5, 1'b0, 1'b0, 1'b0, 1, 1'b0, 1'b0);
        send(8'h11, 1'b0, 1'b0, 1'b0, 1, 1'b0, 1'b0);
        send(8'h22, 1'b0, 1'b0, 1'b0, 1, 1'b0, 1'b0);
        send(8'h33, 1'b0, 1'b0, 1'b0, 1, 1'b0, 1'b0);
        repeat (12) @(negedge clk);
        chk("pre_rst_count", fifo_count, 4'd3);
        chk("pre_rst_busy", tx_busy, 1'b1);
        resetb = 1'b0;
        @(posedge clk);
        #1;
        chk("midrst_line", aux_uart_tx, 1'b1);
        chk("midrst_count", fifo_count, 4'd0);
        chk("midrst_busy", tx_busy, 1'b0);
        chk("midrst_ready", tx_ready, 1'b1);
        @(negedge clk);
        resetb = 1'b1;
        low = 0;
        repeat (30) begin
            @(negedge clk);
            if (aux_uart_tx !== 1'b1) low++;
        end
        chk("post_rst_low_cycles", low, 0);
        chk("post_rst_empty", tx_empty, 1'b1);

        // maximum divisor: start bit must last 65536 clocks
        baud_div = 16'hFFFF;
        send(8'hFF, 1'b0, 1'b0, 1'b0, 65535, 1'b0, 1'b0);
        @(negedge clk);
        chk("maxdiv_k_high", aux_uart_tx, 1'b1);
        @(negedge clk);
        n = 0;
        while (aux_uart_tx == 1'b0 && n < 70000) begin
            n++;
            @(negedge clk);
        end
        chk("maxdiv_start_len", n, 65536);
        chk("maxdiv_bit0", aux_uart_tx, 1'b1);
        chk("maxdiv_busy", tx_busy, 1'b1);
        resetb = 1'b0;
        @(posedge clk);
        #1 resetb = 1'b1;
        @(negedge clk);
        chk("final_line", aux_uart_tx, 1'b1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
